// File: rtl/frame_buffer_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the frame buffer arbiter.
// The slave modport is the arbiter; the master modport is whatever sits around it.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_gnt;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [7:0]        starve_events;

  modport slave (
    input  vga_req, vga_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, sram_dq_in,
    output vga_ack, vga_rdata, vga_rvalid, wr_gnt,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, starve_events
  );

  modport master (
    output vga_req, vga_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, sram_dq_in,
    input  vga_ack, vga_rdata, vga_rvalid, wr_gnt,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, starve_events
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Shares one SRAM frame buffer between a high-priority VGA reader and two round-robin writers,
// inserting a turnaround cycle after writes and forcing a long-waiting writer ahead of VGA.
module frame_buffer_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  frame_buffer_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t            state, state_nxt;
  logic [1:0]        wr_sel;
  logic              force_used;
  logic [1:0]        forced;
  logic              rr;
  logic [CNT_W-1:0]  wait_cnt [2];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q, rvalid_q;
  logic [7:0]        starve_q;
  logic              ack_c;
  logic [1:0]        gnt_c;

  // Among the requesting writers in m, prefer the one the round-robin pointer names.
  function automatic logic [1:0] pick(input logic [1:0] m, input logic p);
    if (m == 2'b11) return p ? 2'b10 : 2'b01;
    return m;
  endfunction

  assign forced[0] = bus.wr_req[0] && (wait_cnt[0] == CNT_MAX);
  assign forced[1] = bus.wr_req[1] && (wait_cnt[1] == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = IDLE;
    wr_sel     = 2'b00;
    force_used = 1'b0;
    case (state)
      IDLE, READ: begin
        if (|forced) begin
          state_nxt  = WRITE;
          wr_sel     = pick(forced, rr);
          force_used = 1'b1;
        end else if (bus.vga_req) begin
          state_nxt = READ;
        end else if (|bus.wr_req) begin
          state_nxt = WRITE;
          wr_sel    = pick(bus.wr_req, rr);
        end
      end
      WRITE: begin
        if ((|bus.wr_req) && !bus.vga_req && !(|forced)) begin
          state_nxt = WRITE;
          wr_sel    = pick(bus.wr_req, rr);
        end else begin
          state_nxt = TURN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_c = (state_nxt == READ);
    gnt_c = wr_sel;
  end

  // SRAM pins are registered from the decision so the strobes are glitch-free at the pads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rr       <= 1'b0;
      starve_q <= 8'd0;
      for (int k = 0; k < 2; k++) wait_cnt[k] <= '0;
    end else begin
      rvalid_q <= (state == READ);
      if (state == READ) rdata_q <= bus.sram_dq_in;
      case (state_nxt)
        READ: begin
          addr_q  <= bus.vga_addr;
          ce_n_q  <= 1'b0;
          oe_n_q  <= 1'b0;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        WRITE: begin
          addr_q   <= wr_sel[1] ? bus.wr_addr1 : bus.wr_addr0;
          dq_out_q <= wr_sel[1] ? bus.wr_data1 : bus.wr_data0;
          ce_n_q   <= 1'b0;
          oe_n_q   <= 1'b1;
          we_n_q   <= 1'b0;
          dq_oe_q  <= 1'b1;
        end
        default: begin
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase
      if (|wr_sel) rr <= wr_sel[0];
      if (force_used && (starve_q != 8'hFF)) starve_q <= starve_q + 8'd1;
      for (int k = 0; k < 2; k++) begin
        if (!bus.wr_req[k] || wr_sel[k])  wait_cnt[k] <= '0;
        else if (wait_cnt[k] != CNT_MAX)  wait_cnt[k] <= wait_cnt[k] + CNT_W'(1);
      end
    end
  end

  assign bus.vga_ack       = ack_c;
  assign bus.wr_gnt        = gnt_c;
  assign bus.vga_rdata     = rdata_q;
  assign bus.vga_rvalid    = rvalid_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_dq_out   = dq_out_q;
  assign bus.sram_dq_oe    = dq_oe_q;
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.starve_events = starve_q;
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: reset, reads, paired writes, write-to-read
// turnaround, writer starvation under constant VGA load, and reset during a write.
module tb_frame_buffer_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  frame_buffer_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  frame_buffer_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #10 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are looked at on the falling edge.
  task automatic apply_stimulus(input logic vreq, input logic [19:0] vaddr,
                                input logic [1:0] wreq, input logic [15:0] dq_in);
    @(posedge clk);
    #1;
    bus.vga_req    = vreq;
    bus.vga_addr   = vaddr;
    bus.wr_req     = wreq;
    bus.sram_dq_in = dq_in;
    @(negedge clk);
  endtask

  function automatic logic overlap();
    return bus.sram_dq_oe && (!bus.sram_oe_n);
  endfunction

  initial begin
    reset_n        = 1'b0;
    bus.vga_req    = 1'b0;
    bus.vga_addr   = '0;
    bus.wr_req     = 2'b00;
    bus.wr_addr0   = 20'h00010;
    bus.wr_data0   = 16'h1111;
    bus.wr_addr1   = 20'h00020;
    bus.wr_data1   = 16'h2222;
    bus.sram_dq_in = '0;

    #35;
    check_output("rst_ce_n",   bus.sram_ce_n, 1);
    check_output("rst_oe_n",   bus.sram_oe_n, 1);
    check_output("rst_we_n",   bus.sram_we_n, 1);
    check_output("rst_dq_oe",  bus.sram_dq_oe, 0);
    check_output("rst_ack",    bus.vga_ack, 0);
    check_output("rst_gnt",    bus.wr_gnt, 0);
    check_output("rst_rvalid", bus.vga_rvalid, 0);
    check_output("rst_starve", bus.starve_events, 0);
    check_output("rst_addr",   bus.sram_addr, 0);
    check_output("rst_rdata",  bus.vga_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] single read");
    apply_stimulus(1'b1, 20'h00123, 2'b00, 16'h0000);
    check_output("rd_ack",     bus.vga_ack, 1);
    check_output("rd_rvalid0", bus.vga_rvalid, 0);
    apply_stimulus(1'b0, 20'h00123, 2'b00, 16'hBEEF);
    check_output("rd_addr",    bus.sram_addr, 20'h00123);
    check_output("rd_oe_n",    bus.sram_oe_n, 0);
    check_output("rd_ce_n",    bus.sram_ce_n, 0);
    check_output("rd_we_n",    bus.sram_we_n, 1);
    check_output("rd_dq_oe",   bus.sram_dq_oe, 0);
    check_output("rd_ack_low", bus.vga_ack, 0);
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("rd_rvalid",  bus.vga_rvalid, 1);
    check_output("rd_rdata",   bus.vga_rdata, 16'hBEEF);
    check_output("rd_oe_off",  bus.sram_oe_n, 1);

    $display("[TB] two writers");
    apply_stimulus(1'b0, 20'h00000, 2'b11, 16'h0000);
    check_output("ww_gnt0",   bus.wr_gnt, 2'b01);
    apply_stimulus(1'b0, 20'h00000, 2'b10, 16'h0000);
    check_output("ww_gnt1",   bus.wr_gnt, 2'b10);
    check_output("ww_we0",    bus.sram_we_n, 0);
    check_output("ww_addr0",  bus.sram_addr, 20'h00010);
    check_output("ww_data0",  bus.sram_dq_out, 16'h1111);
    check_output("ww_oe0",    bus.sram_dq_oe, 1);
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("ww_gnt_no", bus.wr_gnt, 2'b00);
    check_output("ww_we1",    bus.sram_we_n, 0);
    check_output("ww_addr1",  bus.sram_addr, 20'h00020);
    check_output("ww_data1",  bus.sram_dq_out, 16'h2222);
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("ww_turn_oe", bus.sram_dq_oe, 0);
    check_output("ww_turn_we", bus.sram_we_n, 1);
    check_output("ww_turn_ce", bus.sram_ce_n, 1);

    $display("[TB] write then read");
    bus.wr_addr0 = 20'h00030;
    bus.wr_data0 = 16'h3333;
    apply_stimulus(1'b0, 20'h00000, 2'b01, 16'h0000);
    check_output("wr_gnt",     bus.wr_gnt, 2'b01);
    check_output("wr_ack0",    bus.vga_ack, 0);
    apply_stimulus(1'b1, 20'h00456, 2'b00, 16'h0000);
    check_output("wr_we",      bus.sram_we_n, 0);
    check_output("wr_addr",    bus.sram_addr, 20'h00030);
    check_output("wr_data",    bus.sram_dq_out, 16'h3333);
    check_output("wr_ack1",    bus.vga_ack, 0);
    check_output("wr_ovl1",    overlap(), 0);
    apply_stimulus(1'b1, 20'h00456, 2'b00, 16'h0000);
    check_output("wr_turn_oe", bus.sram_dq_oe, 0);
    check_output("wr_ack2",    bus.vga_ack, 0);
    check_output("wr_ovl2",    overlap(), 0);
    apply_stimulus(1'b1, 20'h00456, 2'b00, 16'h0000);
    check_output("wr_ack3",    bus.vga_ack, 1);
    apply_stimulus(1'b0, 20'h00456, 2'b00, 16'hCAFE);
    check_output("wr_rd_oe_n", bus.sram_oe_n, 0);
    check_output("wr_rd_addr", bus.sram_addr, 20'h00456);
    check_output("wr_rd_dqoe", bus.sram_dq_oe, 0);
    check_output("wr_ovl3",    overlap(), 0);
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("wr_rvalid",  bus.vga_rvalid, 1);
    check_output("wr_rdata",   bus.vga_rdata, 16'hCAFE);

    $display("[TB] starvation");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 20'h00100 + 20'(i), 2'b10, 16'h0000);
      check_output("sv_ack_wait", bus.vga_ack, 1);
      check_output("sv_gnt_wait", bus.wr_gnt, 2'b00);
    end
    apply_stimulus(1'b1, 20'h00108, 2'b10, 16'h0000);
    check_output("sv_forced_gnt", bus.wr_gnt, 2'b10);
    check_output("sv_forced_ack", bus.vga_ack, 0);
    apply_stimulus(1'b1, 20'h00108, 2'b00, 16'h0000);
    check_output("sv_we",     bus.sram_we_n, 0);
    check_output("sv_addr",   bus.sram_addr, 20'h00020);
    check_output("sv_events", bus.starve_events, 1);
    check_output("sv_ack_w",  bus.vga_ack, 0);
    apply_stimulus(1'b1, 20'h00108, 2'b00, 16'h0000);
    check_output("sv_turn_oe", bus.sram_dq_oe, 0);
    check_output("sv_ack_t",  bus.vga_ack, 0);
    apply_stimulus(1'b1, 20'h00108, 2'b00, 16'h0000);
    check_output("sv_resume", bus.vga_ack, 1);
    apply_stimulus(1'b0, 20'h00108, 2'b00, 16'h0000);
    check_output("sv_rd_oe_n", bus.sram_oe_n, 0);
    check_output("sv_rd_addr", bus.sram_addr, 20'h00108);

    $display("[TB] reset during write");
    bus.wr_addr0 = 20'h00040;
    bus.wr_data0 = 16'h4444;
    apply_stimulus(1'b0, 20'h00000, 2'b01, 16'h0000);
    check_output("mr_gnt",   bus.wr_gnt, 2'b01);
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("mr_we_pre", bus.sram_we_n, 0);
    check_output("mr_oe_pre", bus.sram_dq_oe, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mr_we",     bus.sram_we_n, 1);
    check_output("mr_dq_oe",  bus.sram_dq_oe, 0);
    check_output("mr_ce",     bus.sram_ce_n, 1);
    check_output("mr_starve", bus.starve_events, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 20'h00000, 2'b00, 16'h0000);
    check_output("mr_post_we", bus.sram_we_n, 1);
    check_output("mr_post_ce", bus.sram_ce_n, 1);
    check_output("mr_post_oe", bus.sram_dq_oe, 0);
    apply_stimulus(1'b1, 20'h00777, 2'b00, 16'h0000);
    check_output("mr_idle_ack", bus.vga_ack, 1);
    apply_stimulus(1'b0, 20'h00777, 2'b00, 16'h0000);
    check_output("mr_rd_oe_n", bus.sram_oe_n, 0);
    check_output("mr_rd_addr", bus.sram_addr, 20'h00777);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares the single off-chip SRAM frame buffer (16-bit words) between three requesters:
  - the VGA pixel prefetcher (read-only, highest priority);
  - two drawing engines (write-only, round-robin between them).
- Sits between the 50 MHz game logic and the SRAM pins.
- Sequences every SRAM cycle and inserts a bus turnaround whenever a write is followed by anything else, so VGA reads never see contention.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- STARVE_MAX, 8, writer-wait cycles after which that writer's next grant is forced ahead of VGA (one slot only)

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA read request; held high until vga_ack
- vga_addr  in  ADDR_W  VGA read address, stable while vga_req is high
- vga_ack  out  1  one-cycle pulse: request accepted this cycle
- vga_rdata  out  DATA_W  read data
- vga_rvalid  out  1  one-cycle pulse: vga_rdata valid
- wr_req  in  2  per-writer write request; held until matching wr_gnt
- wr_addr0, wr_addr1  in  ADDR_W  write addresses
- wr_data0, wr_data1  in  DATA_W  write data
- wr_gnt  out  2  one-hot, one-cycle pulse: write performed this cycle
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_dq_out  out  DATA_W  data driven to SRAM
- sram_dq_oe  out  1  tri-state enable for sram_dq_out
- sram_dq_in  in  DATA_W  data read from SRAM
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active-low, registered
- starve_events  out  8  saturating count of forced writer grants (debug/LEDG)

Behaviour:
- Reset values (asynchronous):
  - state=IDLE;
  - all ack, gnt and rvalid outputs 0;
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0;
  - sram_addr=0, vga_rdata=0;
  - round-robin pointer rr=0;
  - both wait counters 0;
  - starve_events=0.
- FSM states: IDLE, READ, WRITE, TURN. Decisions use the current-cycle inputs; strobes are registered.
- IDLE / READ decision:
  - If a forced writer is pending, go to WRITE for that writer.
  - Else if vga_req, go to READ: vga_ack=1 this cycle; next cycle sram_addr=vga_addr, ce_n=0, oe_n=0, we_n=1.
  - Else if any wr_req, go to WRITE for the rr winner.
  - Else go to IDLE with all strobes deasserted.
- READ is followed by the same decision. Read→write needs no turnaround: sram_dq_oe rises together with we_n falling.
- WRITE for writer k:
  - wr_gnt[k]=1 in the decision cycle;
  - next cycle: sram_addr=wr_addrk, sram_dq_out=wr_datak, dq_oe=1, ce_n=0, we_n=0, oe_n=1;
  - rr toggles to the other writer after every grant.
- WRITE continuation:
  - If another wr_req is pending, vga_req is low and no forced grant applies, WRITE→WRITE back-to-back.
  - Otherwise WRITE→TURN.
- TURN: one cycle with dq_oe=0 and all strobes deasserted, then back to the IDLE decision.
- Read latency: vga_ack in cycle t, SRAM read in cycle t+1, sram_dq_in registered into vga_rdata at the end of t+1, vga_rvalid=1 in cycle t+2.
  - Back-to-back reads sustain one word per cycle.
  - Worst-case vga_req→vga_ack is 3 cycles: WRITE, then TURN, then decision.
- Starvation:
  - wait counter k increments each cycle wr_req[k] is high without a grant;
  - it clears on grant or when wr_req[k] drops;
  - when it reaches STARVE_MAX, writer k is forced: it wins the next decision even over vga_req;
  - each force increments starve_events, saturating at 255.
- Simultaneous writers with no VGA request: rr decides; the loser waits at least one slot.
- wr_req dropped before its grant: treated as withdrawn, no write performed.
- Reset asserted mid-operation: strobes return to inactive immediately (asynchronously) and sram_dq_oe drops the same instant; no partial write completes afterwards.

Test Plan:
- Reset: reset_n=0 → ce_n=oe_n=we_n=1, dq_oe=0, all pulses 0, starve_events=0.
- Single read: vga_req=1, vga_addr=0x00123, sram_dq_in=0xBEEF → ack at t, sram_addr=0x00123 with oe_n=0 at t+1, vga_rvalid=1 and vga_rdata=0xBEEF at t+2.
- Two writers together, no VGA:
  - wr_req=2'b11 with addr0=0x10/data0=0x1111 and addr1=0x20/data1=0x2222;
  - required: gnt 01 then 10 on consecutive cycles, two back-to-back we_n=0 cycles, then one TURN cycle with dq_oe=0.
- Write then read:
  - writer0 granted, vga_req rises the next cycle;
  - required: TURN cycle with dq_oe=0 before the read, vga_ack 2 cycles after vga_req, and ce_n/oe_n=0 never overlapping dq_oe=1.
- Starvation: vga_req held high continuously, wr_req[1]=1 → after 8 wait cycles wr_gnt=2'b10 once, starve_events=1, VGA reads resume afterwards.
- Mid-write reset: reset_n=0 during a we_n=0 cycle → we_n=1 and dq_oe=0 immediately, FSM in IDLE after reset release.
